// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the DataMemory arbiter: FSM states and requester ids.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick between the CPU and DMA requesters.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = cpu_req | dma_req;
    // On contention the port that was not served last wins.
    if (cpu_req && dma_req) grant_id = ~last_grant;
    else if (dma_req)       grant_id = REQ_DMA;
    else                    grant_id = REQ_CPU;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemory between the CPU MEM stage and the DMA engine
// using a latch / access / respond sequence with round-robin arbitration.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  CpuReq,
  input  logic                  CpuWrite,
  input  logic [ADDR_WIDTH-1:0] CpuAddress,
  input  logic [DATA_WIDTH-1:0] CpuWriteData,
  output logic                  CpuAck,
  output logic [DATA_WIDTH-1:0] CpuReadData,
  output logic                  CpuStall,
  input  logic                  DmaReq,
  input  logic                  DmaWrite,
  input  logic [ADDR_WIDTH-1:0] DmaAddress,
  input  logic [DATA_WIDTH-1:0] DmaWriteData,
  output logic                  DmaAck,
  output logic [DATA_WIDTH-1:0] DmaReadData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] ReadData
);

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  grant_valid;
  logic                  grant_id;

  rr_arbiter2 u_rr (
    .cpu_req     (CpuReq),
    .dma_req     (DmaReq),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      last_grant  <= REQ_DMA;
      owner       <= REQ_CPU;
      cmd_write   <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      CpuAck      <= 1'b0;
      DmaAck      <= 1'b0;
      CpuReadData <= '0;
      DmaReadData <= '0;
    end else begin
      case (state)
        IDLE: begin
          CpuAck <= 1'b0;
          DmaAck <= 1'b0;
          if (grant_valid) begin
            owner      <= grant_id;
            last_grant <= grant_id;
            if (grant_id == REQ_DMA) begin
              cmd_write <= DmaWrite;
              cmd_addr  <= DmaAddress;
              cmd_wdata <= DmaWriteData;
              MemRead   <= ~DmaWrite;
              MemWrite  <= DmaWrite;
            end else begin
              cmd_write <= CpuWrite;
              cmd_addr  <= CpuAddress;
              cmd_wdata <= CpuWriteData;
              MemRead   <= ~CpuWrite;
              MemWrite  <= CpuWrite;
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // The write commits and read data is captured on this same edge.
          MemRead  <= 1'b0;
          MemWrite <= 1'b0;
          if (!cmd_write) begin
            if (owner == REQ_DMA) DmaReadData <= ReadData;
            else                  CpuReadData <= ReadData;
          end
          CpuAck <= (owner == REQ_CPU);
          DmaAck <= (owner == REQ_DMA);
          state  <= RESP;
        end
        RESP: begin
          CpuAck <= 1'b0;
          DmaAck <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Address   = cmd_addr;
  assign WriteData = cmd_wdata;
  assign CpuStall  = CpuReq & ~CpuAck;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: DataMemory model plus a transaction-level reference of
// memory contents, round-robin order and per-port read data registers.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        CpuReq, CpuWrite, DmaReq, DmaWrite;
  logic [31:0] CpuAddress, CpuWriteData, DmaAddress, DmaWriteData;
  logic        CpuAck, CpuStall, DmaAck, MemWrite, MemRead;
  logic [31:0] CpuReadData, DmaReadData, Address, WriteData, ReadData;

  bit   [31:0] ram     [64];
  bit   [31:0] ref_mem [64];
  bit          m_last;
  logic [31:0] m_cpu_rd, m_dma_rd;
  int          total = 0;
  int          bad   = 0;

  dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .CpuReq(CpuReq), .CpuWrite(CpuWrite), .CpuAddress(CpuAddress),
    .CpuWriteData(CpuWriteData), .CpuAck(CpuAck), .CpuReadData(CpuReadData),
    .CpuStall(CpuStall),
    .DmaReq(DmaReq), .DmaWrite(DmaWrite), .DmaAddress(DmaAddress),
    .DmaWriteData(DmaWriteData), .DmaAck(DmaAck), .DmaReadData(DmaReadData),
    .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .ReadData(ReadData)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (MemWrite) ram[Address[7:2]] <= WriteData;
  assign ReadData = ram[Address[7:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_memread", {31'd0, MemRead}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_cpu_rd", CpuReadData, 32'd0);
    check("rst_dma_rd", DmaReadData, 32'd0);
    m_last = 1'b1;
    m_cpu_rd = '0;
    m_dma_rd = '0;
  endtask

  // Issues up to one request per port in the same cycle and checks every cycle
  // of the following window against the predicted service order.
  task automatic run_pair(input bit ce, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                          input bit de, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                          input int hold, input bit perturb);
    bit          id [2];
    bit          sw [2];
    logic [31:0] sa [2];
    logic [31:0] sd [2];
    int          n = 0;
    int          cpu_t = -1;
    int          dma_t = -1;
    logic [31:0] exp_cpu_rd, exp_dma_rd;
    if (ce && de) begin id[0] = ~m_last; id[1] = m_last; n = 2; end
    else if (ce) begin id[0] = 1'b0; n = 1; end
    else if (de) begin id[0] = 1'b1; n = 1; end
    for (int k = 0; k < n; k++) begin
      sw[k] = id[k] ? dw : cw;
      sa[k] = id[k] ? da : ca;
      sd[k] = id[k] ? dd : cd;
      if (sw[k]) ref_mem[sa[k][7:2]] = sd[k];
      else if (id[k]) m_dma_rd = ref_mem[sa[k][7:2]];
      else m_cpu_rd = ref_mem[sa[k][7:2]];
      if (id[k]) dma_t = 2 + 3 * k; else cpu_t = 2 + 3 * k;
      m_last = id[k];
    end
    exp_cpu_rd = m_cpu_rd;
    exp_dma_rd = m_dma_rd;
    CpuReq = ce; CpuWrite = cw; CpuAddress = ca; CpuWriteData = cd;
    DmaReq = de; DmaWrite = dw; DmaAddress = da; DmaWriteData = dd;
    for (int t = 1; t <= 8; t++) begin
      int acc = -1;
      @(negedge Clk);
      if (perturb && t == 1) begin CpuAddress = 32'h20; CpuWriteData = ~cd; end
      #1;
      for (int k = 0; k < n; k++) if (t == 1 + 3 * k) acc = k;
      check("mem_read", {31'd0, MemRead}, {31'd0, (acc >= 0) && !sw[(acc >= 0) ? acc : 0]});
      check("mem_write", {31'd0, MemWrite}, {31'd0, (acc >= 0) && sw[(acc >= 0) ? acc : 0]});
      if (acc >= 0) begin
        check("address", Address, sa[acc]);
        check("write_data", WriteData, sd[acc]);
      end
      check("cpu_ack", {31'd0, CpuAck}, {31'd0, t == cpu_t});
      check("dma_ack", {31'd0, DmaAck}, {31'd0, t == dma_t});
      check("cpu_stall", {31'd0, CpuStall}, {31'd0, CpuReq && (t != cpu_t)});
      if (t == cpu_t) check("cpu_rdata", CpuReadData, exp_cpu_rd);
      if (t == dma_t) check("dma_rdata", DmaReadData, exp_dma_rd);
      if (cpu_t > 0 && t == cpu_t + hold) CpuReq = 1'b0;
      if (dma_t > 0 && t == dma_t) DmaReq = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    CpuReq = 0; CpuWrite = 0; CpuAddress = 0; CpuWriteData = 0;
    DmaReq = 0; DmaWrite = 0; DmaAddress = 0; DmaWriteData = 0;
    m_last = 1'b1; m_cpu_rd = '0; m_dma_rd = '0;
    repeat (2) @(negedge Clk);
    check("rst_address", Address, 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_mem_rw", {30'd0, MemRead, MemWrite}, 32'd0);
    check("rst_acks", {30'd0, CpuAck, DmaAck}, 32'd0);
    check("rst_cpu_rd0", CpuReadData, 32'd0);
    check("rst_dma_rd0", DmaReadData, 32'd0);
    Reset = 1'b0;

    // CPU write then read back
    run_pair(1, 1, 32'h4, 32'h2, 0, 0, 0, 0, 0, 0);
    run_pair(1, 0, 32'h4, 32'h0, 0, 0, 0, 0, 0, 0);

    // Simultaneous CPU read / DMA write to the same word after reset
    apply_reset();
    run_pair(1, 0, 32'h8, 32'h0, 1, 1, 32'h8, 32'hDEADBEEF, 0, 0);
    run_pair(1, 0, 32'h8, 32'h0, 0, 0, 0, 0, 0, 0);

    // Sustained contention: six accesses alternating from CPU
    apply_reset();
    for (int i = 0; i < 3; i++)
      run_pair(1, 0, 32'h4, 32'h0, 1, 1, 32'h10 + 4 * i, 32'h100 + i, 0, 0);

    // Address change after the grant edge is ignored
    run_pair(1, 1, 32'h10, 32'hCAFE0010, 0, 0, 0, 0, 0, 1);

    // Reset during ACCESS of a DMA write
    @(negedge Clk);
    DmaReq = 1; DmaWrite = 1; DmaAddress = 32'hC; DmaWriteData = 32'h12345678;
    @(negedge Clk);
    check("mid_memwrite_on", {31'd0, MemWrite}, 32'd1);
    Reset = 1'b1;
    #1;
    check("mid_memwrite_off", {31'd0, MemWrite}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    DmaReq = 0;
    m_last = 1'b1; m_cpu_rd = '0; m_dma_rd = '0;
    repeat (3) begin
      @(negedge Clk);
      check("mid_no_ack", {31'd0, DmaAck}, 32'd0);
    end
    run_pair(1, 0, 32'hC, 32'h0, 0, 0, 0, 0, 0, 0);

    // Request held through its own Ack cycle yields a single access
    run_pair(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 1, 0);
    run_pair(0, 0, 0, 0, 1, 1, 32'h14, 32'h55AA55AA, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      bit ce, de;
      ce = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      if (!ce && !de) ce = 1'b1;
      run_pair(ce, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
               de, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
               0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
